// File: rtl/prbs_seq_pkg.sv
// rtl/prbs_seq_pkg.sv - shared types and constants for the PRBS self-test sequencer
package prbs_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SEND,
      ST_WAIT,
      ST_DONE
   } seq_state_t;

   localparam int PATTERN_LEN     = 4;
   localparam int DEFAULT_TIMEOUT = 64;
   localparam int MAX_REP         = 7;

   // Byte 0 is the most significant byte of the pattern.
   function automatic logic [7:0] pattern_byte(input logic [31:0] pattern, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0: b = pattern[31:24];
         2'd1: b = pattern[23:16];
         2'd2: b = pattern[15:8];
         2'd3: b = pattern[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/prbs_test_sequencer.sv
// rtl/prbs_test_sequencer.sv - streams a captured pattern into the PRBS datapath and grades the detector flag
module prbs_test_sequencer
   import prbs_seq_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] pattern_in,
   input  logic [2:0]  rep_n,
   input  logic        dp_flag,
   output logic        dp_rst,
   output logic [7:0]  dp_data,
   output logic [2:0]  dp_n,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        cfg_err
);

   localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   seq_state_t    state;
   logic [31:0]   pattern_q;
   logic [4:0]    send_cnt;
   logic [4:0]    next_idx;
   logic [4:0]    last_idx;
   logic [TW-1:0] tmo_cnt;
   logic          flag_lat;

   // dp_n doubles as the captured repeat count for the whole run.
   assign last_idx = 5'(PATTERN_LEN * int'(dp_n) - 1);
   assign next_idx = send_cnt + 5'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         pattern_q <= 32'h0;
         send_cnt  <= 5'd0;
         tmo_cnt   <= '0;
         flag_lat  <= 1'b0;
         dp_rst    <= 1'b0;
         dp_data   <= 8'h00;
         dp_n      <= 3'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         dp_rst  <= 1'b1;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (rep_n != 3'd0 && int'(rep_n) <= MAX_REP) begin
                     pattern_q <= pattern_in;
                     dp_n      <= rep_n;
                     pass      <= 1'b0;
                     flag_lat  <= 1'b0;
                     busy      <= 1'b1;
                     dp_rst    <= 1'b0;
                     dp_data   <= 8'h00;
                     state     <= ST_CLEAR;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               send_cnt <= 5'd0;
               dp_data  <= pattern_byte(pattern_q, 2'd0);
               state    <= ST_SEND;
            end
            ST_SEND: begin
               flag_lat <= flag_lat | dp_flag;
               if (send_cnt == last_idx) begin
                  dp_data <= 8'h00;
                  // A flag seen anywhere during SEND skips the wait phase.
                  if (flag_lat || dp_flag) begin
                     pass  <= 1'b1;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     tmo_cnt <= '0;
                     state   <= ST_WAIT;
                  end
               end else begin
                  send_cnt <= next_idx;
                  dp_data  <= pattern_byte(pattern_q, next_idx[1:0]);
               end
            end
            ST_WAIT: begin
               if (dp_flag) begin
                  pass  <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (tmo_cnt == T_LAST) begin
                  pass  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
